// File: rtl/frame_dma_scheduler.sv
// Frame DMA scheduler: copies one frame from the frame store to GFX VRAM per GFX interrupt,
// and services keyboard interrupts that select which frame is copied.
module frame_dma_scheduler #(
    parameter int          FRAME_BITS   = 2,
    parameter int          WORD_BITS    = 10,
    parameter int          DATA_WIDTH   = 16,
    parameter logic [15:0] KEY_BASE     = 16'h0031,
    parameter bit          AUTO_ADVANCE = 1'b0
) (
    input  logic                            CLK,
    input  logic                            IN_PB_RESET,
    output logic                            mem_en,
    output logic [FRAME_BITS+WORD_BITS-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            gfx_irq,
    output logic                            gfx_iack,
    output logic                            gfx_iend,
    output logic                            gfx_en,
    output logic                            gfx_we,
    output logic [15:0]                     gfx_addr,
    output logic [DATA_WIDTH-1:0]           gfx_wdata,
    input  logic                            kbd_irq,
    output logic                            kbd_iack,
    output logic                            kbd_iend,
    output logic                            kbd_en,
    input  logic [15:0]                     kbd_rdata,
    output logic [FRAME_BITS-1:0]           cur_frame,
    output logic                            busy
);

    localparam int NUM_FRAMES = 2 ** FRAME_BITS;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_G_ACK = 4'd1,
        S_G_RD  = 4'd2,
        S_G_LAT = 4'd3,
        S_G_WR  = 4'd4,
        S_G_END = 4'd5,
        S_K_ACK = 4'd6,
        S_K_RD  = 4'd7,
        S_K_LAT = 4'd8,
        S_K_END = 4'd9
    } state_t;

    state_t                  state, state_nx;
    logic [FRAME_BITS-1:0]   frame;
    logic [WORD_BITS-1:0]    idx;
    logic [DATA_WIDTH-1:0]   wbuf;
    logic [15:0]             kbuf;
    logic [16:0]             key_off;
    logic                    key_ok;

    // Widened subtraction so keys below KEY_BASE show up as a borrow rather than wrapping.
    assign key_off = {1'b0, kbuf} - {1'b0, KEY_BASE};
    assign key_ok  = !key_off[16] && (key_off < 17'(NUM_FRAMES));

    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) state <= S_IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE: begin
                if (kbd_irq)      state_nx = S_K_ACK;
                else if (gfx_irq) state_nx = S_G_ACK;
                else              state_nx = S_IDLE;
            end
            S_G_ACK: state_nx = S_G_RD;
            S_G_RD:  state_nx = S_G_LAT;
            S_G_LAT: state_nx = S_G_WR;
            S_G_WR:  state_nx = (&idx) ? S_G_END : S_G_RD;
            S_G_END: state_nx = S_IDLE;
            S_K_ACK: state_nx = S_K_RD;
            S_K_RD:  state_nx = S_K_LAT;
            S_K_LAT: state_nx = S_K_END;
            S_K_END: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Frame only moves at the end of a service, so the frame bits of mem_addr hold for a copy.
    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) begin
            frame <= '0;
            idx   <= '0;
            wbuf  <= '0;
            kbuf  <= '0;
        end else begin
            case (state)
                S_G_ACK: idx  <= '0;
                S_G_LAT: wbuf <= mem_rdata;
                S_G_WR:  idx  <= idx + WORD_BITS'(1);
                S_G_END: if (AUTO_ADVANCE) frame <= frame + FRAME_BITS'(1);
                S_K_LAT: kbuf <= kbd_rdata;
                S_K_END: if (key_ok) frame <= key_off[FRAME_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en   = 1'b0;
        gfx_iack = 1'b0;
        gfx_iend = 1'b0;
        gfx_en   = 1'b0;
        gfx_we   = 1'b0;
        kbd_iack = 1'b0;
        kbd_iend = 1'b0;
        kbd_en   = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_G_ACK: gfx_iack = 1'b1;
            S_G_RD:  mem_en   = 1'b1;
            S_G_WR: begin
                gfx_en = 1'b1;
                gfx_we = 1'b1;
            end
            S_G_END: gfx_iend = 1'b1;
            S_K_ACK: kbd_iack = 1'b1;
            S_K_RD:  kbd_en   = 1'b1;
            S_K_END: kbd_iend = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr  = {frame, idx};
    assign gfx_addr  = 16'(idx);
    assign gfx_wdata = wbuf;
    assign cur_frame = frame;

endmodule

// File: tb/tb_frame_dma_scheduler.sv
// Directed bench for frame_dma_scheduler; a second instance runs with AUTO_ADVANCE=1 in lockstep.
module tb_frame_dma_scheduler;

    logic        CLK, IN_PB_RESET;
    logic        gfx_irq, kbd_irq;
    logic [15:0] kbd_rdata, key_val;

    logic        mem_en, gfx_iack, gfx_iend, gfx_en, gfx_we, kbd_iack, kbd_iend, kbd_en, busy;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata, gfx_addr, gfx_wdata;
    logic [1:0]  cur_frame;

    logic        mem_en_b, gfx_iack_b, gfx_iend_b, gfx_en_b, gfx_we_b;
    logic        kbd_iack_b, kbd_iend_b, kbd_en_b, busy_b;
    logic [11:0] mem_addr_b;
    logic [15:0] mem_rdata_b, gfx_addr_b, gfx_wdata_b;
    logic [1:0]  cur_frame_b;

    int total = 0;
    int bad   = 0;

    int cyc_g_iack, cyc_g_iend, cyc_k_iack, cyc_k_en, cyc_k_iend, cyc_idle;
    int n_wr, n_wbad, n_abad, n_giend, n_kiend, b_bad;
    logic [1:0] idle_frame, b_frame;
    bit b_seen;

    frame_dma_scheduler dut (
        .CLK(CLK), .IN_PB_RESET(IN_PB_RESET),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .gfx_irq(gfx_irq), .gfx_iack(gfx_iack), .gfx_iend(gfx_iend),
        .gfx_en(gfx_en), .gfx_we(gfx_we), .gfx_addr(gfx_addr), .gfx_wdata(gfx_wdata),
        .kbd_irq(kbd_irq), .kbd_iack(kbd_iack), .kbd_iend(kbd_iend),
        .kbd_en(kbd_en), .kbd_rdata(kbd_rdata),
        .cur_frame(cur_frame), .busy(busy)
    );

    frame_dma_scheduler #(.AUTO_ADVANCE(1'b1)) dut_b (
        .CLK(CLK), .IN_PB_RESET(IN_PB_RESET),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .gfx_irq(gfx_irq), .gfx_iack(gfx_iack_b), .gfx_iend(gfx_iend_b),
        .gfx_en(gfx_en_b), .gfx_we(gfx_we_b), .gfx_addr(gfx_addr_b), .gfx_wdata(gfx_wdata_b),
        .kbd_irq(kbd_irq), .kbd_iack(kbd_iack_b), .kbd_iend(kbd_iend_b),
        .kbd_en(kbd_en_b), .kbd_rdata(kbd_rdata),
        .cur_frame(cur_frame_b), .busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Frame store word at address a holds 16'hA000 + a; keyboard returns garbage unless read.
    always @(posedge CLK) begin
        if (mem_en)   mem_rdata   <= 16'hA000 + {4'h0, mem_addr};
        if (mem_en_b) mem_rdata_b <= 16'hA000 + {4'h0, mem_addr_b};
        kbd_rdata <= kbd_en ? key_val : 16'hDEAD;
    end

    // Steps cycles (cycle 1 = first cycle after irq is sampled), acting as both peripherals.
    task automatic observe(input int max_cyc, input bit stop_idle, input logic [1:0] exp_frame,
                           input int kbd_at);
        logic [15:0] ed;
        cyc_g_iack = -1; cyc_g_iend = -1; cyc_k_iack = -1; cyc_k_en = -1;
        cyc_k_iend = -1; cyc_idle = -1;
        n_wr = 0; n_wbad = 0; n_abad = 0; n_giend = 0; n_kiend = 0; b_bad = 0;
        b_seen = 0; b_frame = '0; idle_frame = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge CLK);
            if (c == kbd_at) kbd_irq = 1'b1;
            if (gfx_iack) begin gfx_irq = 1'b0; if (cyc_g_iack < 0) cyc_g_iack = c; end
            if (kbd_iack) begin kbd_irq = 1'b0; if (cyc_k_iack < 0) cyc_k_iack = c; end
            if (kbd_en && cyc_k_en < 0) cyc_k_en = c;
            if (gfx_iend) begin n_giend++; if (cyc_g_iend < 0) cyc_g_iend = c; end
            if (kbd_iend) begin n_kiend++; if (cyc_k_iend < 0) cyc_k_iend = c; end
            if (mem_en && mem_addr[11:10] !== exp_frame) n_abad++;
            if (gfx_en) begin
                ed = 16'hA000 + {4'h0, exp_frame, n_wr[9:0]};
                if (!gfx_we || n_wr >= 1024 || gfx_addr !== {6'h0, n_wr[9:0]} || gfx_wdata !== ed)
                    n_wbad++;
                n_wr++;
            end
            if (mem_en_b) begin
                if (!b_seen) begin b_frame = mem_addr_b[11:10]; b_seen = 1; end
                else if (mem_addr_b[11:10] !== b_frame) b_bad++;
            end
            if (gfx_en_b && gfx_wdata_b !== 16'hA000 + {4'h0, b_frame, gfx_addr_b[9:0]}) b_bad++;
            if ({mem_en_b, gfx_iack_b, gfx_iend_b, gfx_en_b, gfx_we_b, kbd_iack_b, kbd_iend_b,
                 kbd_en_b, busy_b} !== {mem_en, gfx_iack, gfx_iend, gfx_en, gfx_we, kbd_iack,
                 kbd_iend, kbd_en, busy}) b_bad++;
            if (!busy && cyc_idle < 0) begin
                cyc_idle = c;
                idle_frame = cur_frame;
                if (stop_idle) break;
            end
        end
    endtask

    task automatic do_key(input logic [15:0] k, input logic [1:0] ef);
        key_val = k;
        kbd_irq = 1'b1;
        observe(20, 1'b1, ef, 0);
    endtask

    task automatic test_reset;
        IN_PB_RESET = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({mem_en, gfx_iack, gfx_iend, gfx_en, gfx_we, kbd_iack, kbd_iend, kbd_en, busy} !== 9'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=0",
                {mem_en, gfx_iack, gfx_iend, gfx_en, gfx_we, kbd_iack, kbd_iend, kbd_en, busy});
        end
        total++;
        if (mem_addr !== 12'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++;
        if (gfx_addr !== 16'h0) begin bad++; $display("FAIL reset_gfx_addr got=%h want=0", gfx_addr); end
        total++;
        if (gfx_wdata !== 16'h0) begin bad++; $display("FAIL reset_gfx_wdata got=%h want=0", gfx_wdata); end
        total++;
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL reset_cur_frame got=%0d want=0", cur_frame); end
        IN_PB_RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_gfx_copy;
        gfx_irq = 1'b1;
        observe(3100, 1'b1, 2'd0, 0);
        total++;
        if (cyc_g_iack !== 1) begin bad++; $display("FAIL copy_iack_cycle got=%0d want=1", cyc_g_iack); end
        total++;
        if (cyc_g_iend !== 3074) begin bad++; $display("FAIL copy_iend_cycle got=%0d want=3074", cyc_g_iend); end
        total++;
        if (cyc_idle !== 3075) begin bad++; $display("FAIL copy_idle_cycle got=%0d want=3075", cyc_idle); end
        total++;
        if (n_wr !== 1024) begin bad++; $display("FAIL copy_write_count got=%0d want=1024", n_wr); end
        total++;
        if (n_wbad !== 0) begin bad++; $display("FAIL copy_write_data bad_writes=%0d want=0", n_wbad); end
        total++;
        if (n_abad !== 0) begin bad++; $display("FAIL copy_read_frame bad_reads=%0d want=0", n_abad); end
        total++;
        if (n_giend !== 1) begin bad++; $display("FAIL copy_iend_count got=%0d want=1", n_giend); end
    endtask

    task automatic test_reset_mid_copy;
        int iends;
        logic [15:0] a500;
        logic        w500;
        iends = 0;
        gfx_irq = 1'b1;
        for (int c = 1; c <= 1504; c++) begin
            @(negedge CLK);
            if (gfx_iack) gfx_irq = 1'b0;
            if (gfx_iend) iends++;
        end
        w500 = gfx_en;
        a500 = gfx_addr;
        total++;
        if (!w500 || a500 !== 16'd500) begin
            bad++; $display("FAIL midcopy_word500 got en=%b addr=%0d want en=1 addr=500", w500, a500);
        end
        IN_PB_RESET = 1'b0;
        @(negedge CLK);
        if (gfx_iend) iends++;
        total++;
        if ({mem_en, gfx_iack, gfx_iend, gfx_en, gfx_we, kbd_iack, kbd_iend, kbd_en, busy} !== 9'b0) begin
            bad++; $display("FAIL midcopy_reset_strobes got=%b want=0",
                {mem_en, gfx_iack, gfx_iend, gfx_en, gfx_we, kbd_iack, kbd_iend, kbd_en, busy});
        end
        total++;
        if (cur_frame !== 2'd0) begin bad++; $display("FAIL midcopy_cur_frame got=%0d want=0", cur_frame); end
        total++;
        if (iends !== 0) begin bad++; $display("FAIL midcopy_no_iend got=%0d want=0", iends); end
        IN_PB_RESET = 1'b1;
        @(negedge CLK);
        gfx_irq = 1'b1;
        observe(3100, 1'b1, 2'd0, 0);
        total++;
        if (cyc_g_iack !== 1) begin bad++; $display("FAIL restart_iack got=%0d want=1", cyc_g_iack); end
        total++;
        if (n_wr !== 1024 || n_wbad !== 0) begin
            bad++; $display("FAIL restart_writes got=%0d bad=%0d want=1024 bad=0", n_wr, n_wbad);
        end
    endtask

    task automatic test_key_select;
        do_key(16'h0033, 2'd0);
        total++;
        if (cyc_k_iack !== 1) begin bad++; $display("FAIL key_iack got=%0d want=1", cyc_k_iack); end
        total++;
        if (cyc_k_en !== 2) begin bad++; $display("FAIL key_en got=%0d want=2", cyc_k_en); end
        total++;
        if (cyc_k_iend !== 4) begin bad++; $display("FAIL key_iend got=%0d want=4", cyc_k_iend); end
        total++;
        if (cyc_idle !== 5 || idle_frame !== 2'd2) begin
            bad++; $display("FAIL key_frame got idle=%0d frame=%0d want idle=5 frame=2", cyc_idle, idle_frame);
        end
        gfx_irq = 1'b1;
        observe(3100, 1'b1, 2'd2, 0);
        total++;
        if (n_abad !== 0) begin bad++; $display("FAIL frame2_addr bad_reads=%0d want=0", n_abad); end
        total++;
        if (n_wr !== 1024 || n_wbad !== 0) begin
            bad++; $display("FAIL frame2_writes got=%0d bad=%0d want=1024 bad=0", n_wr, n_wbad);
        end
    endtask

    task automatic test_invalid_key;
        logic [15:0] keys [5];
        logic [1:0]  want [5];
        logic [1:0]  prev;
        keys = '{16'h0035, 16'h0030, 16'h8031, 16'h0034, 16'h0031};
        want = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        prev = 2'd2;
        for (int i = 0; i < 5; i++) begin
            do_key(keys[i], prev);
            total++;
            if (idle_frame !== want[i] || cur_frame !== want[i]) begin
                bad++; $display("FAIL key_%h_frame got=%0d want=%0d", keys[i], cur_frame, want[i]);
            end
            total++;
            if (n_kiend !== 1) begin bad++; $display("FAIL key_%h_iend_count got=%0d want=1", keys[i], n_kiend); end
            prev = want[i];
        end
    endtask

    task automatic test_simultaneous;
        key_val = 16'h0032;
        kbd_irq = 1'b1;
        gfx_irq = 1'b1;
        observe(3090, 1'b0, 2'd1, 0);
        total++;
        if (cyc_k_iack !== 1) begin bad++; $display("FAIL simul_kbd_first got=%0d want=1", cyc_k_iack); end
        total++;
        if (cyc_idle !== 5) begin bad++; $display("FAIL simul_kbd_idle got=%0d want=5", cyc_idle); end
        total++;
        if (cyc_g_iack !== 6) begin bad++; $display("FAIL simul_gfx_iack got=%0d want=6", cyc_g_iack); end
        total++;
        if (cyc_g_iend !== 3079) begin bad++; $display("FAIL simul_gfx_iend got=%0d want=3079", cyc_g_iend); end
        total++;
        if (n_wr !== 1024 || n_wbad !== 0 || n_abad !== 0) begin
            bad++; $display("FAIL simul_copy got=%0d wbad=%0d abad=%0d want=1024 0 0", n_wr, n_wbad, n_abad);
        end
    endtask

    task automatic test_kbd_during_copy;
        key_val = 16'h0034;
        gfx_irq = 1'b1;
        observe(3100, 1'b1, 2'd1, 1000);
        total++;
        if (cyc_k_iack !== -1) begin bad++; $display("FAIL during_no_preempt got=%0d want=-1", cyc_k_iack); end
        total++;
        if (cyc_g_iend !== 3074 || n_wbad !== 0 || n_abad !== 0) begin
            bad++; $display("FAIL during_copy iend=%0d wbad=%0d abad=%0d want=3074 0 0", cyc_g_iend, n_wbad, n_abad);
        end
        observe(20, 1'b1, 2'd1, 0);
        total++;
        if (cyc_k_iack !== 1 || idle_frame !== 2'd3) begin
            bad++; $display("FAIL during_key_after got iack=%0d frame=%0d want 1 3", cyc_k_iack, idle_frame);
        end
    endtask

    task automatic test_auto_advance;
        logic [1:0] eb;
        do_key(16'h0034, 2'd3);
        for (int i = 0; i < 4; i++) begin
            eb = 2'(i + 3);
            gfx_irq = 1'b1;
            observe(3100, 1'b1, 2'd3, 0);
            total++;
            if (b_frame !== eb) begin bad++; $display("FAIL auto_copy%0d_frame got=%0d want=%0d", i, b_frame, eb); end
            total++;
            if (b_bad !== 0) begin bad++; $display("FAIL auto_copy%0d_data bad=%0d want=0", i, b_bad); end
            total++;
            if (n_abad !== 0) begin bad++; $display("FAIL fixed_copy%0d_frame bad_reads=%0d want=0", i, n_abad); end
        end
        total++;
        if (cur_frame_b !== 2'd3 || cur_frame !== 2'd3) begin
            bad++; $display("FAIL auto_final got b=%0d a=%0d want 3 3", cur_frame_b, cur_frame);
        end
    endtask

    initial begin
        IN_PB_RESET = 1'b0;
        gfx_irq     = 1'b0;
        kbd_irq     = 1'b0;
        key_val     = 16'h0;
        test_reset;
        test_gfx_copy;
        test_reset_mid_copy;
        test_key_select;
        test_invalid_key;
        test_simultaneous;
        test_kbd_during_copy;
        test_auto_advance;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
